// File: rtl/cla_pkg.sv
// Shared definitions for the CLA long-add sequencer.
//   cla_state_e : sequencer states (idle, p/g/h capture, prefix levels, result hold)
//   CLA_W       : default operand width
//   clog2       : ceiling log2, used to derive the number of prefix levels
package cla_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PG     = 2'd1,
        S_PREFIX = 2'd2,
        S_DONE   = 2'd3
    } cla_state_e;

    localparam int CLA_W = 31;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_pg_stage.sv
// Per-bit propagate / generate / half-sum terms of the CLA datapath.
// Purely combinational.
//   a, b : operands (W bits)
//   p    : a | b   (propagate)
//   g    : a & b   (generate)
//   h    : a ^ b   (half sum)
module cla_pg_stage
    import cla_pkg::*;
#(
    parameter int W = CLA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p,
    output logic [W-1:0] g,
    output logic [W-1:0] h
);

    assign p = a | b;
    assign g = a & b;
    assign h = a ^ b;

endmodule

// File: rtl/cla_add_sequencer.sv
// Multi-cycle long adder: captures an operand pair on a valid/ready handshake,
// forms p/g/h, resolves carries with a Kogge-Stone prefix one level per cycle,
// and presents sum/cout on a valid/ready handshake held under backpressure.
//
// Optional feature macro CLA_SEQ_SUB_EN adds a subtract mode (port sub) and a
// signed-overflow flag (port ovf).
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only in IDLE, low in reset)
//   a, b, cin           : operands and carry in
//   sub (optional)      : 1 = compute a - b
//   out_valid/out_ready : result handshake, result held until accepted
//   sum, cout           : a + b + cin modulo 2^W and carry out
//   ovf (optional)      : signed overflow of the operation
//   busy                : high whenever an operation is in flight
module cla_add_sequencer
    import cla_pkg::*;
#(
    parameter int W = CLA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic         sub,
    output logic         ovf,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int LVL   = clog2(W);
    localparam int CNT_W = clog2(LVL + 1);

    cla_state_e state_q, state_d;

    logic [W-1:0]     a_q, b_q;
    logic             cin_q;
    logic [W-1:0]     p_q, g_q, h_q;
    logic [CNT_W-1:0] cnt_q;

    logic [W-1:0]     pg_p, pg_g, pg_h;
    logic [W-1:0]     p_nxt, g_nxt;
    logic [W:0]       c;
    logic [W-1:0]     sum_nxt;
    logic             last_lvl;

    // Operand conditioning at capture: subtract is a + ~b + 1.
    logic [W-1:0]     b_in;
    logic             cin_in;
`ifdef CLA_SEQ_SUB_EN
    assign b_in   = sub ? ~b : b;
    assign cin_in = sub | cin;
`else
    assign b_in   = b;
    assign cin_in = cin;
`endif

    cla_pg_stage #(.W(W)) u_pg (
        .a (a_q),
        .b (b_q),
        .p (pg_p),
        .g (pg_g),
        .h (pg_h)
    );

    assign last_lvl  = (cnt_q == CNT_W'(LVL - 1));
    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);

    // One Kogge-Stone level selected by cnt_q; bits below the span pass through.
    always_comb begin
        g_nxt = g_q;
        p_nxt = p_q;
        for (int k = 0; k < LVL; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                for (int i = (1 << k); i < W; i++) begin
                    g_nxt[i] = g_q[i] | (p_q[i] & g_q[i - (1 << k)]);
                    p_nxt[i] = p_q[i] & p_q[i - (1 << k)];
                end
            end
        end
    end

    // After the last level G/P are group terms over [i:0], so every carry
    // needs only cin; sum is taken from the level being written this edge.
    always_comb begin
        c    = '0;
        c[0] = cin_q;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g_nxt[i] | (p_nxt[i] & cin_q);
        end
        sum_nxt = h_q ^ c[W-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid) state_d = S_PG;
            S_PG:     state_d = S_PREFIX;
            S_PREFIX: if (last_lvl) state_d = S_DONE;
            S_DONE:   if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            p_q     <= '0;
            g_q     <= '0;
            h_q     <= '0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            ovf     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b_in;
                        cin_q <= cin_in;
                    end
                end
                S_PG: begin
                    p_q   <= pg_p;
                    g_q   <= pg_g;
                    h_q   <= pg_h;
                    cnt_q <= '0;
                end
                S_PREFIX: begin
                    p_q   <= p_nxt;
                    g_q   <= g_nxt;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_lvl) begin
                        sum  <= sum_nxt;
                        cout <= c[W];
`ifdef CLA_SEQ_SUB_EN
                        // b_q already holds the effective (possibly inverted) operand.
                        ovf  <= (a_q[W-1] == b_q[W-1]) && (sum_nxt[W-1] != a_q[W-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Directed bench for cla_add_sequencer (W = 31).
module tb_cla_add_sequencer;

    localparam int W = 31;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef CLA_SEQ_SUB_EN
    logic         sub;
    logic         ovf;
    logic         exp_ovf;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    cla_add_sequencer #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub       (sub),
        .ovf       (ovf),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Accept one operand pair, wait for the result and check latency and value.
    // out_valid must be seen 6 edges after the accept edge (7th edge counting it).
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                            input logic [W-1:0] es, input logic ec, input string tag);
        int   lat;
        logic busy_ok;
        a        = ta;
        b        = tb_v;
        cin      = tc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 0;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 20) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) busy_ok = 1'b0;
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd6);
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
`ifdef CLA_SEQ_SUB_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`endif
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_hs_vld"}, 64'(out_valid), 64'd0);
        check({tag, "_hs_busy"}, 64'(busy), 64'd0);
        check({tag, "_hs_rdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int   lat;
        logic seen;
        logic stable;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        sub       = 1'b0;
        exp_ovf   = 1'b0;
`endif

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // 5 + 3
        start_op(31'd5, 31'd3, 1'b0, 31'd8, 1'b0, "add5_3");
        finish_op("add5_3");

        // Reset while in PREFIX with cnt=2: op discarded, sum cleared
        a        = 31'd1;
        b        = 31'd1;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        seen     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("midrst_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("midrst_no_valid", 64'(seen), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);

        // Full carry ripple
        start_op(31'h7FFF_FFFF, 31'd0, 1'b1, 31'd0, 1'b1, "ripple");
        finish_op("ripple");

        // Alternating pattern then 20 cycles of backpressure with in_valid asserted
        start_op(31'h5555_5555, 31'h2AAA_AAAA, 1'b1, 31'd0, 1'b1, "alt");
        a        = 31'd1;
        b        = 31'd1;
        cin      = 1'b0;
        in_valid = 1'b1;
        stable   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b1 || sum !== 31'd0 || cout !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_stable", 64'(stable), 64'd1);
        finish_op("alt");
        check("bp_sum_kept", 64'(sum), 64'd0);

        // Back-to-back with in_valid held and out_ready high
        a         = 31'd5;
        b         = 31'd3;
        cin       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        a   = 31'd8;
        b   = 31'd8;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("b2b1_lat", 64'(lat), 64'd6);
        check("b2b1_sum", 64'(sum), 64'd8);
        tick();
        check("b2b_gap_vld", 64'(out_valid), 64'd0);
        check("b2b_gap_rdy", 64'(in_ready), 64'd1);
        tick();
        check("b2b2_accepted", 64'(busy), 64'd1);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("b2b2_lat", 64'(lat), 64'd6);
        check("b2b2_sum", 64'(sum), 64'h10);
        check("b2b2_cout", 64'(cout), 64'd0);
        tick();
        out_ready = 1'b0;
        check("b2b2_done", 64'(out_valid), 64'd0);

        // Further boundary vectors
        start_op(31'h7FFF_FFFF, 31'h7FFF_FFFF, 1'b1, 31'h7FFF_FFFF, 1'b1, "max");
        finish_op("max");
        start_op(31'h1234_5678, 31'h0FED_CBA9, 1'b0, 31'h2222_2221, 1'b0, "mixed");
        finish_op("mixed");
        start_op(31'h4000_0000, 31'h4000_0000, 1'b0, 31'd0, 1'b1, "topbit");
        finish_op("topbit");

`ifdef CLA_SEQ_SUB_EN
        sub     = 1'b1;
        exp_ovf = 1'b0;
        start_op(31'd10, 31'd3, 1'b0, 31'd7, 1'b1, "sub10_3");
        finish_op("sub10_3");
        exp_ovf = 1'b1;
        start_op(31'h3FFF_FFFF, 31'h4000_0000, 1'b0, 31'h7FFF_FFFF, 1'b0, "sub_ovf");
        finish_op("sub_ovf");
        sub     = 1'b0;
        exp_ovf = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
